// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the N-bit carry chain is split
// into STAGES segments, each closed by a register stage with valid/ready flow control.
module pipelined_addsub #(
   parameter int unsigned N      = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned W = N / STAGES;
   localparam int unsigned L = STAGES - 1;

   // Per-stage registers; operands travel full-width so higher segments reach their stage.
   logic [STAGES-1:0] v;
   logic [N-1:0]      xq [STAGES];
   logic [N-1:0]      yq [STAGES];
   logic [N-1:0]      sq [STAGES];
   logic [STAGES-1:0] cq;
   logic [STAGES-1:0] subq;
   logic              coutq;
   logic              ovfq;

   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] vin;
   logic [N-1:0]      a_c [STAGES];
   logic [N-1:0]      b_c [STAGES];
   logic [N-1:0]      s_c [STAGES];
   logic [STAGES-1:0] c_c;
   logic [STAGES-1:0] sub_c;
   logic [STAGES-1:0] co_c;
   logic [W:0]        seg;
   logic              nxt;
   logic              ovf_c;
   logic              cout_c;

   always_comb begin
      adv    = '0;
      vin    = '0;
      c_c    = '0;
      sub_c  = '0;
      co_c   = '0;
      seg    = '0;
      nxt    = 1'b0;
      ovf_c  = 1'b0;
      cout_c = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         a_c[k] = '0;
         b_c[k] = '0;
         s_c[k] = '0;
      end

      // A stage advances when empty or when its successor advances.
      nxt    = out_ready || !v[L];
      adv[L] = nxt;
      for (int unsigned i = 1; i < STAGES; i++) begin
         nxt      = !v[L-i] || nxt;
         adv[L-i] = nxt;
      end

      vin[0]   = in_valid;
      a_c[0]   = x;
      b_c[0]   = sub ? ~y : y;
      c_c[0]   = cin ^ sub;
      sub_c[0] = sub;
      s_c[0]   = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         vin[k]   = v[k-1];
         a_c[k]   = xq[k-1];
         b_c[k]   = yq[k-1];
         c_c[k]   = cq[k-1];
         sub_c[k] = subq[k-1];
         s_c[k]   = sq[k-1];
      end

      for (int unsigned k = 0; k < STAGES; k++) begin
         seg = {1'b0, a_c[k][k*W +: W]} + {1'b0, b_c[k][k*W +: W]} + {{W{1'b0}}, c_c[k]};
         s_c[k][k*W +: W] = seg[W-1:0];
         co_c[k]          = seg[W];
      end

      // Carry into the MSB is recovered as a^b^s at that bit.
      ovf_c  = a_c[L][N-1] ^ b_c[L][N-1] ^ s_c[L][N-1] ^ co_c[L];
      cout_c = co_c[L] ^ sub_c[L];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v     <= '0;
         cq    <= '0;
         subq  <= '0;
         coutq <= 1'b0;
         ovfq  <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            xq[k] <= '0;
            yq[k] <= '0;
            sq[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               v[k] <= vin[k];
               if (vin[k]) begin
                  xq[k]   <= a_c[k];
                  yq[k]   <= b_c[k];
                  sq[k]   <= s_c[k];
                  cq[k]   <= co_c[k];
                  subq[k] <= sub_c[k];
               end
            end
         end
         if (adv[L] && vin[L]) begin
            coutq <= cout_c;
            ovfq  <= ovf_c;
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v[L];
   assign s         = sq[L];
   assign cout      = coutq;
   assign ovf       = ovfq;

endmodule
